// File: rtl/masking_pkg.sv
// Shared helpers for the masked datapath gadgets.
// Shares are packed share-major: share i occupies bits [i*WIDTH +: WIDTH].
//   nrnd(s)          : number of fresh random words per transfer, s*(s-1)/2
//   rnd_idx(i,j,s)   : randomness word shared by share pair {i,j} (symmetric)
//   pair_idx(i,j,s)  : dense index of ordered pair (i,j), i != j
//   share_lsb(i,w)   : lowest bit of share i
package masking_pkg;

  localparam int unsigned DEF_SHARES = 3;
  localparam int unsigned DEF_WIDTH  = 1;

  function automatic int unsigned nrnd(input int unsigned s);
    return s * (s - 1) / 2;
  endfunction

  function automatic int unsigned rnd_idx(input int unsigned i, input int unsigned j,
                                          input int unsigned s);
    int unsigned lo;
    int unsigned hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * s - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned s);
    return i * (s - 1) + ((j < i) ? j : j - 1);
  endfunction

  function automatic int unsigned share_lsb(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/hpc2_en_reg.sv
// Pipeline register with load enable and synchronous active-low reset to 0.
// Every gadget register goes through this module so the keep attribute
// applies uniformly and the t/u terms can never be retimed or merged away.
// Ports: clk, rst_n, en (load enable), d (next value), q (registered value).
module hpc2_en_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* keep = "true" *) logic [WIDTH-1:0] q_r;

  always_ff @(posedge clk) begin
    if (!rst_n)  q_r <= '0;
    else if (en) q_r <= d;
  end

  assign q = q_r;

endmodule

// File: rtl/and_hpc2_pipe.sv
// HPC2 masked AND gadget with valid/ready handshake and a stallable pipeline.
// c = a & b on shared data (share-major packing); rnd is consumed on input fire.
// Optional macro AND_HPC2_PIPE_OUTREG_EN adds a third register stage on c.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   input handshake for a, b, rnd
//   a, b                  SHARES*WIDTH shared operands
//   rnd                   nrnd(SHARES)*WIDTH fresh randomness
//   out_valid / out_ready output handshake for c
//   c                     SHARES*WIDTH shared result
module and_hpc2_pipe
  import masking_pkg::*;
#(
  parameter int unsigned SHARES = DEF_SHARES,
  parameter int unsigned WIDTH  = DEF_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SHARES*WIDTH-1:0]          a,
  input  logic [SHARES*WIDTH-1:0]          b,
  input  logic [nrnd(SHARES)*WIDTH-1:0]    rnd,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SHARES*WIDTH-1:0]          c
);

  localparam int unsigned NRND  = nrnd(SHARES);
  localparam int unsigned NPAIR = SHARES * (SHARES - 1);
  localparam int unsigned SW    = SHARES * WIDTH;

  logic v1, v2, en1, en2, in_fire, ld2;
  logic [SW-1:0]          a1, p1, p1_d, p2, c_comb;
  logic [NRND*WIDTH-1:0]  rr;
  logic [NPAIR*WIDTH-1:0] bx_d, bx, t_d, u_d, t, u;

  assign en1      = ~v1 | en2;
  assign in_ready = en1;
  assign in_fire  = in_valid & en1;
  assign ld2      = en2 & v1;

  // Stage 1 inputs: only same-share products and b_j masked by r_ij.
  always_comb begin
    p1_d = a & b;
    bx_d = '0;
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        if (i != j) begin
          bx_d[pair_idx(i, j, SHARES)*WIDTH +: WIDTH] =
            b[share_lsb(j, WIDTH) +: WIDTH] ^ rnd[rnd_idx(i, j, SHARES)*WIDTH +: WIDTH];
        end
      end
    end
  end

  hpc2_en_reg #(.WIDTH(1))           u_v1  (.clk(clk), .rst_n(rst_n), .en(en1),     .d(in_fire), .q(v1));
  hpc2_en_reg #(.WIDTH(SW))          u_a1  (.clk(clk), .rst_n(rst_n), .en(in_fire), .d(a),       .q(a1));
  hpc2_en_reg #(.WIDTH(SW))          u_p1  (.clk(clk), .rst_n(rst_n), .en(in_fire), .d(p1_d),    .q(p1));
  hpc2_en_reg #(.WIDTH(NRND*WIDTH))  u_rr  (.clk(clk), .rst_n(rst_n), .en(in_fire), .d(rnd),     .q(rr));
  hpc2_en_reg #(.WIDTH(NPAIR*WIDTH)) u_bx  (.clk(clk), .rst_n(rst_n), .en(in_fire), .d(bx_d),    .q(bx));

  // Stage 2 inputs: cross terms only ever see registered, masked b.
  always_comb begin
    t_d = '0;
    u_d = '0;
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        if (i != j) begin
          t_d[pair_idx(i, j, SHARES)*WIDTH +: WIDTH] =
            ~a1[share_lsb(i, WIDTH) +: WIDTH] & rr[rnd_idx(i, j, SHARES)*WIDTH +: WIDTH];
          u_d[pair_idx(i, j, SHARES)*WIDTH +: WIDTH] =
            a1[share_lsb(i, WIDTH) +: WIDTH] & bx[pair_idx(i, j, SHARES)*WIDTH +: WIDTH];
        end
      end
    end
  end

  hpc2_en_reg #(.WIDTH(1))           u_v2  (.clk(clk), .rst_n(rst_n), .en(en2), .d(v1),  .q(v2));
  hpc2_en_reg #(.WIDTH(SW))          u_p2  (.clk(clk), .rst_n(rst_n), .en(ld2), .d(p1),  .q(p2));
  hpc2_en_reg #(.WIDTH(NPAIR*WIDTH)) u_t   (.clk(clk), .rst_n(rst_n), .en(ld2), .d(t_d), .q(t));
  hpc2_en_reg #(.WIDTH(NPAIR*WIDTH)) u_u   (.clk(clk), .rst_n(rst_n), .en(ld2), .d(u_d), .q(u));

  // Share compression from stage-2 registers only.
  always_comb begin
    c_comb = p2;
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        if (i != j) begin
          c_comb[share_lsb(i, WIDTH) +: WIDTH] = c_comb[share_lsb(i, WIDTH) +: WIDTH]
            ^ t[pair_idx(i, j, SHARES)*WIDTH +: WIDTH]
            ^ u[pair_idx(i, j, SHARES)*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef AND_HPC2_PIPE_OUTREG_EN
  logic          v3, en3;
  logic [SW-1:0] c3;

  assign en3 = ~v3 | out_ready;
  assign en2 = ~v2 | en3;

  hpc2_en_reg #(.WIDTH(1))  u_v3 (.clk(clk), .rst_n(rst_n), .en(en3),      .d(v2),     .q(v3));
  hpc2_en_reg #(.WIDTH(SW)) u_c3 (.clk(clk), .rst_n(rst_n), .en(en3 & v2), .d(c_comb), .q(c3));

  assign out_valid = v3;
  assign c         = c3;
`else
  assign en2       = ~v2 | out_ready;
  assign out_valid = v2;
  assign c         = c_comb;
`endif

endmodule
